// File: rtl/seq_wide_adder.sv
// seq_wide_adder
//   Multi-cycle WIDTH-bit adder. Operands are latched on the input handshake,
//   then one SLICE-bit chunk per cycle passes through a SLICE+1-bit
//   ripple-carry slice. The carry between chunks lives only in r_carry.
//   The result is held with out_valid until the consumer takes it.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a, b, cin valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry-in to slice 0, sampled on the accept edge
//   out_valid  sum/cout/ovf valid (DONE only)
//   out_ready  consumer accepts result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of the MSB
//   ovf        two's-complement overflow
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// ADD   | one slice per cycle, r_idx selects the chunk
// DONE  | result held, out_valid=1 until out_ready
module seq_wide_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [SLICE-1:0]  w_a_slc;
  logic [SLICE-1:0]  w_b_slc;
  logic [SLICE:0]    w_slc;
  logic              w_last;

  // Chunk selection and the ripple-carry slice itself.
  assign w_a_slc = r_a[r_idx*SLICE +: SLICE];
  assign w_b_slc = r_b[r_idx*SLICE +: SLICE];
  assign w_slc   = {1'b0, w_a_slc} + {1'b0, w_b_slc} + {{SLICE{1'b0}}, r_carry};
  assign w_last  = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum[r_idx*SLICE +: SLICE] <= w_slc[SLICE-1:0];
          r_carry                     <= w_slc[SLICE];
          if (w_last) begin
            r_cout  <= w_slc[SLICE];
            // The top chunk's slice MSB is the new sum MSB.
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                       (w_slc[SLICE-1] != r_a[WIDTH-1]);
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_wide_adder.sv
module tb_seq_wide_adder;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int N     = WIDTH / SLICE;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  seq_wide_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } exp_t;

  exp_t exp_q[$];
  int   rise_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  logic prev_ov  = 1'b0;
  logic prev_or  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci);
    exp_t e;
    logic [WIDTH:0] t;
    t   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    e.s = t[WIDTH-1:0];
    e.c = t[WIDTH];
    e.v = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  // Offer operands until accepted; push the expected result on the accept edge.
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    bit done = 0;
    in_valid = 1'b1;
    a = x; b = y; cin = ci;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(x, y, ci));
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (done) acc_cyc = cyc;
    else check("accept_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    if (!done) check("drain_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: latency, scoreboard compare, single-cycle handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("pulse_after_hs", {63'd0, out_valid && prev_ov && prev_or}, 64'd0);
      if (out_valid) begin
        if (!prev_ov) begin
          check("latency", 64'(cyc - acc_cyc), 64'(N));
          rise_q.push_back(cyc);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sum",  64'(sum),  64'(e.s));
            check("cout", 64'(cout), 64'(e.c));
            check("ovf",  64'(ovf),  64'(e.v));
          end
        end
      end
    end
    prev_ov = out_valid && !rst;
    prev_or = out_ready;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_cout",      64'(cout),      64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;

    // Basic add and latency.
    send(32'd1, 32'd2, 1'b1);
    drain();

    // Carry ripples through every slice via the carry register.
    send(32'hFFFF_FFFF, 32'd0, 1'b1);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("carry_chain", 64'(dut.r_carry), 64'd1);
    end
    drain();

    // Signed overflow both directions.
    send(32'h7FFF_FFFF, 32'd1, 1'b0);
    drain();
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();

    // Backpressure: result held, new operands ignored.
    out_ready = 1'b0;
    send(32'd81, 32'd18, 1'b1);
    begin
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      if (!seen) check("bp_valid_timeout", 64'd1, 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'd35; b = 32'd45; cin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_sum",       64'(sum),       64'd100);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_after_hs", 64'(in_ready), 64'd1);
    send(32'd35, 32'd45, 1'b0);
    drain();

    // Reset during the second ADD cycle discards the result.
    send(32'd56, 32'd7, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_sum",       64'(sum),       64'd0);
    check("abort_cout",      64'(cout),      64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    send(32'd56, 32'd7, 1'b1);
    drain();

    // Back-to-back throughput.
    rise_q.delete();
    send(32'd34, 32'd78, 1'b0);
    send(32'd29, 32'd9,  1'b0);
    send(32'd44, 32'd13, 1'b1);
    send(32'd70, 32'd19, 1'b0);
    drain();
    check("b2b_count", 64'(rise_q.size()), 64'd4);
    if (rise_q.size() == 4) begin
      for (int k = 0; k < 3; k++)
        check("b2b_spacing", 64'(rise_q[k+1] - rise_q[k]), 64'(N + 2));
    end

    // A few random operations.
    for (int k = 0; k < 8; k++) begin
      send($urandom, $urandom, 1'($urandom));
      drain();
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
